// File: rtl/jt51_sh_pkg.sv
// Shared definitions for the slot-aware shift register: sweep FSM encoding
// and the slot-index width rule.
package jt51_sh_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } sweep_st_t;

   // Slot index width; a two-slot ring still needs one bit.
   function automatic int slotw(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/jt51_sh_slot_if.sv
// Control/data bundle of one slot shift register: stage-0 inputs, overwrite
// request, clear request and the slot/tap/drop observation outputs.
interface jt51_sh_slot_if #(
   parameter int width  = 5,
   parameter int stages = 32
);
   localparam int SLOTW = jt51_sh_pkg::slotw(stages);

   logic             cen;
   logic [width-1:0] din;
   logic             hold;
   logic             wr_en;
   logic [SLOTW-1:0] wr_slot;
   logic [width-1:0] wr_data;
   logic             clr;
   logic [width-1:0] drop;
   logic [width-1:0] tap_out;
   logic [SLOTW-1:0] slot;
   logic             zero;
   logic             busy;

   modport master (
      output cen, din, hold, wr_en, wr_slot, wr_data, clr,
      input  drop, tap_out, slot, zero, busy
   );

   modport slave (
      input  cen, din, hold, wr_en, wr_slot, wr_data, clr,
      output drop, tap_out, slot, zero, busy
   );
endinterface

// File: rtl/jt51_sh_slotcnt.sv
// Slot counter and clear-sweep sequencer for the slot shift register.
//   state | meaning
//   IDLE  | normal shifting, stage 0 fed from din / wr_data / drop
//   SWEEP | clear rotation in progress, stage 0 fed with init
module jt51_sh_slotcnt
   import jt51_sh_pkg::*;
#(
   parameter  int stages = 32,
   localparam int SLOTW  = slotw(stages)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cen,
   input  logic             clr,
   input  logic [SLOTW-1:0] wr_slot,
   output logic [SLOTW-1:0] slot,
   output logic             zero,
   output logic             busy,
   output logic             match,
   output logic             sweep
);
   localparam logic [SLOTW-1:0] SLOT_LAST = SLOTW'(stages - 1);
   localparam logic [SLOTW-1:0] SLOT_ONE  = SLOTW'(1);
   localparam logic [SLOTW:0]   CNT_START = (SLOTW+1)'(stages - 1);
   localparam logic [SLOTW:0]   CNT_ONE   = (SLOTW+1)'(1);
   localparam logic [SLOTW:0]   SLOT_SPAN = (SLOTW+1)'(stages);

   sweep_st_t        st_q, st_d;
   logic [SLOTW:0]   cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         slot <= '0;
      end else if (cen) begin
         slot <= (slot == SLOT_LAST) ? '0 : slot + SLOT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q  <= IDLE;
         cnt_q <= '0;
      end else if (cen) begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
      end
   end

   // The starting pulse already clears one slot, so the down-counter holds
   // the remaining stages-1 pulses.
   always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      case (st_q)
         IDLE: begin
            if (clr) begin
               st_d  = SWEEP;
               cnt_d = CNT_START;
            end
         end
         SWEEP: begin
            if (cnt_q == CNT_ONE) begin
               st_d  = IDLE;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            st_d  = IDLE;
            cnt_d = '0;
         end
      endcase
   end

   assign busy  = (st_q == SWEEP);
   assign sweep = busy | clr;
   assign zero  = (slot == '0);
   assign match = (wr_slot == slot) && ({1'b0, wr_slot} < SLOT_SPAN);

endmodule

// File: rtl/jt51_sh_slot.sv
// Slot-aware delay line: width x stages shift array with addressed overwrite,
// recirculation, one-rotation clear and an intermediate tap.
module jt51_sh_slot
   import jt51_sh_pkg::*;
#(
   parameter int               width  = 5,
   parameter int               stages = 32,
   parameter int               tap    = 16,
   parameter logic [width-1:0] init   = '0
) (
   input logic           clk,
   input logic           rst,
   jt51_sh_slot_if.slave sh
);
   logic [width-1:0] sr [stages];
   logic [width-1:0] s0;
   logic             match;
   logic             sweep;

   jt51_sh_slotcnt #(
      .stages (stages)
   ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .cen     (sh.cen),
      .clr     (sh.clr),
      .wr_slot (sh.wr_slot),
      .slot    (sh.slot),
      .zero    (sh.zero),
      .busy    (sh.busy),
      .match   (match),
      .sweep   (sweep)
   );

   always_comb begin
      s0 = sh.din;
      if (sweep) begin
         s0 = init;
      end else if (sh.wr_en && match) begin
         s0 = sh.wr_data;
      end else if (sh.hold) begin
         s0 = sr[stages-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < stages; i++) sr[i] <= init;
      end else if (sh.cen) begin
         sr[0] <= s0;
         for (int i = 1; i < stages; i++) sr[i] <= sr[i-1];
      end
   end

   assign sh.drop    = sr[stages-1];
   assign sh.tap_out = sr[tap-1];

endmodule
